// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer behind the uart core.
// Turns the core's level-style data_ready into one push per received byte.
// Stores bytes in a circular FIFO with a first-word-fall-through read port.
// Raises a sticky overflow flag when a byte arrives with no free slot.
module uart_rx_fifo #(
  parameter int unsigned   DATA_WIDTH = 8,
  // Must be a power of two and at least 2 so the wrap-bit pointer scheme holds.
  parameter int unsigned   DEPTH      = 16,
  localparam int unsigned  ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_ready,
  input  logic                  rd_en,
  input  logic                  clr_overflow,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  localparam int unsigned PtrWidth = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic                  rx_ready_q;
  logic                  overflow_q, overflow_d;

  logic                  push;
  logic                  pop;
  logic                  wr_en;
  logic                  drop;

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
  assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

  // Status flags derived from the wrap-bit pointers.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_addr == rd_addr) && (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    count = wr_ptr_q - rd_ptr_q;
  end

  // Push on the rising edge of rx_ready; pop only when data is present.
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  always_comb begin
    push  = rx_ready & ~rx_ready_q;
    pop   = rd_en & ~empty;
    wr_en = push & (~full | pop);
    drop  = push & full & ~pop;
  end

  // Next-state for pointers and the sticky overflow flag (set beats clear).
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PtrWidth'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrWidth'(1);
    end
    if (clr_overflow) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rx_ready_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rx_ready_q <= rx_ready;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= rx_data;
    end
  end

  // Fall-through read port, forced to zero while nothing is stored.
  always_comb begin
    rd_data = '0;
    if (!empty) begin
      rd_data = mem[rd_addr];
    end
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo.
module tb_uart_rx_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] rx_data;
  logic          rx_ready;
  logic          rd_en;
  logic          clr_overflow;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          full;
  logic [4:0]    count;
  logic          overflow;

  int n_tests;
  int n_fail;

  uart_rx_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .rd_en        (rd_en),
    .clr_overflow (clr_overflow),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One byte from the uart: rx_ready rises for a cycle, then drops.
  task automatic push_byte(input logic [DW-1:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick();
  endtask

  task automatic pop_byte();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    rx_data      = 8'h00;
    rx_ready     = 1'b1;
    rd_en        = 1'b0;
    clr_overflow = 1'b0;

    // Reset held with rx_ready high.
    repeat (3) tick();
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_rd_data", rd_data, 0);
    rx_ready = 1'b0;
    rst_n    = 1'b1;
    repeat (3) tick();
    check("rel_no_push", count, 0);

    // Single byte with rx_ready held high for 50 cycles.
    rx_data  = 8'hA5;
    rx_ready = 1'b1;
    repeat (50) tick();
    check("hold_count", count, 1);
    check("hold_rd_data", rd_data, 8'hA5);
    check("hold_empty", empty, 0);
    rx_ready = 1'b0;
    tick();
    pop_byte();
    check("pop1_empty", empty, 1);
    check("pop1_count", count, 0);

    // rd_en while empty must not move the read pointer.
    rd_en = 1'b1;
    repeat (3) tick();
    rd_en = 1'b0;
    check("rd_empty_count", count, 0);

    // Ordering and pointer wrap.
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    check("fill_full", full, 1);
    check("fill_count", count, 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("order_a%0d", i), rd_data, i);
      pop_byte();
    end
    check("drain_a_count", count, 0);
    for (int i = 16; i < 24; i++) push_byte(8'(i));
    check("wrap_count", count, 8);
    for (int i = 16; i < 24; i++) begin
      check($sformatf("order_b%0d", i), rd_data, i);
      pop_byte();
    end
    check("drain_b_count", count, 0);
    check("drain_b_empty", empty, 1);

    // Full and overflow.
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    check("full2_full", full, 1);
    check("full2_count", count, 16);
    push_byte(8'hEE);
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 16);
    check("ovf_head", rd_data, 8'h20);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("ovf_clr", overflow, 0);
    // Drop and clear in the same cycle: the set wins.
    rx_data      = 8'hEF;
    rx_ready     = 1'b1;
    clr_overflow = 1'b1;
    tick();
    rx_ready     = 1'b0;
    clr_overflow = 1'b0;
    tick();
    check("ovf_set_wins", overflow, 1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("ovf_clr2", overflow, 0);

    // Push and pop together while full.
    rx_data  = 8'h55;
    rx_ready = 1'b1;
    rd_en    = 1'b1;
    tick();
    rx_ready = 1'b0;
    rd_en    = 1'b0;
    tick();
    check("sim_full_count", count, 16);
    check("sim_full_ovf", overflow, 0);
    for (int i = 1; i < 16; i++) begin
      check($sformatf("sim_order%0d", i), rd_data, 8'h20 + i);
      pop_byte();
    end
    check("sim_last", rd_data, 8'h55);
    pop_byte();
    check("sim_empty", empty, 1);

    // Push and pop together while empty: pop ignored.
    rx_data  = 8'h66;
    rx_ready = 1'b1;
    rd_en    = 1'b1;
    tick();
    rx_ready = 1'b0;
    rd_en    = 1'b0;
    check("sim_empty_count", count, 1);
    check("sim_empty_data", rd_data, 8'h66);

    // Asynchronous reset between edges with 5 entries stored.
    tick();
    for (int i = 0; i < 4; i++) push_byte(8'h70 + 8'(i));
    check("pre_rst_count", count, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_count", count, 0);
    check("async_empty", empty, 1);
    check("async_rd_data", rd_data, 0);

    // Release with rx_ready already high: exactly one push.
    rx_data  = 8'h3C;
    rx_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("rel_high_count", count, 1);
    check("rel_high_data", rd_data, 8'h3C);
    rx_ready = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer that sits directly downstream of the uart core. It captures each completed byte from the core's data_out/data_ready pair and stores it in a circular FIFO. A consumer drains it through a first-word-fall-through read port. The core's data_ready is a level that stays high until the next start bit, so this block converts it to a one-shot push and flags bytes lost to overflow.

Parameters:
DATA_WIDTH, 8, byte width; matches uart data_out.
DEPTH, 16, FIFO entries; must be a power of 2 and at least 2.
ADDR_WIDTH, $clog2(DEPTH), pointer index width; derived, not overridden.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous, active-low reset.
rx_data  input  DATA_WIDTH  received byte; connects to uart data_out.
rx_ready  input  1  byte-complete level; connects to uart data_ready.
rd_en  input  1  consumer pop request.
clr_overflow  input  1  clears the sticky overflow flag.
rd_data  output  DATA_WIDTH  oldest stored byte; valid while empty=0.
empty  output  1  FIFO holds 0 entries.
full  output  1  FIFO holds DEPTH entries.
count  output  ADDR_WIDTH+1  number of stored entries, 0..DEPTH.
overflow  output  1  sticky flag: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (rst_n=0, async): wr_ptr=0, rd_ptr=0, rx_ready_q=0, overflow=0. Outputs: count=0, empty=1, full=0, rd_data=0 (gated while empty). Memory contents are not reset.
- Edge detect: rx_ready_q <= rx_ready every cycle. push = rx_ready & ~rx_ready_q, so there is exactly one push per rising edge of rx_ready. rx_data is sampled in the same cycle as push. Holding rx_ready high never causes a second push.
- Pointers are ADDR_WIDTH+1 bits. The low bits index memory and the MSB is the wrap bit. Both pointers wrap modulo 2*DEPTH.
- empty = (wr_ptr == rd_ptr).
- full = (low bits equal) & (MSBs differ).
- count = wr_ptr - rd_ptr, computed modulo 2^(ADDR_WIDTH+1).
- Write: on push & ~full, mem[wr_ptr] <= rx_data and wr_ptr increments. Latency: the byte is visible on rd_data and empty deasserts the cycle after the push edge.
- Read (FWFT): rd_data = mem[rd_ptr low bits] combinationally whenever empty=0, and reads 0 when empty. pop = rd_en & ~empty advances rd_ptr. rd_data shows the next entry in the following cycle.
- rd_en while empty: ignored; no pointer change, no error flag.
- Push and pop in the same cycle, not full and not empty: both occur; count unchanged.
- Push and pop in the same cycle while full: the pop frees a slot, so the push is accepted. count stays DEPTH and overflow is not set.
- Push while empty with rd_en=1: the push is accepted and the pop is ignored. count becomes 1.
- Push while full with no pop: the byte is dropped, wr_ptr is unchanged, and overflow <= 1.
- overflow clears only on clr_overflow=1. If set and clear occur in the same cycle, set wins.
- Reset mid-operation: all stored data is discarded immediately, and the async reset values apply. After rst_n rises, rx_ready_q=0. If rx_ready is already high, one push occurs on the first clock. The uart core resets data_ready to 0, so in the normal system no spurious push occurs.

Test Plan:
- Reset: hold rst_n=0, drive rx_ready=1 -> empty=1, full=0, count=0, overflow=0. Release with rx_ready=0 -> no push.
- Single byte: rx_data=0xA5, rx_ready 0->1 held for 50 cycles -> count=1 exactly, rd_data=0xA5, empty=0. Pulse rd_en -> empty=1, count=0.
- Ordering/wrap: push 0x00..0x0F, pop all, push 0x10..0x17, pop all -> bytes read in order. Pointers wrap past 16 with no loss, and count returns to 0.
- Full/overflow: push 16 bytes -> full=1, count=16. A 17th byte 0xEE -> dropped, overflow=1, and rd_data still shows the first byte. clr_overflow=1 -> overflow=0.
- Simultaneous: while full, assert rd_en in the same cycle as a push of 0x55 -> count stays 16, overflow stays 0, and 0x55 is read last. While empty, rd_en with a push of 0x66 -> count=1, rd_data=0x66.
- Async reset mid-stream: 5 entries stored, pull rst_n low between clock edges -> count=0 and empty=1 without waiting for a clock edge.
